// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad number-entry block.
//   - 4-bit key codes for the sixteen keys of the 4x4 matrix
//   - scan FSM state encoding
//   - key_lookup(row, col): maps a matrix position to its key code
package keypad_pkg;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_RELEASE  = 2'd2
    } scan_state_t;

    // Layout:  r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D
    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = KEY_D;
        case ({row, col})
            4'h0: code = KEY_1;
            4'h1: code = KEY_2;
            4'h2: code = KEY_3;
            4'h3: code = KEY_A;
            4'h4: code = KEY_4;
            4'h5: code = KEY_5;
            4'h6: code = KEY_6;
            4'h7: code = KEY_B;
            4'h8: code = KEY_7;
            4'h9: code = KEY_8;
            4'hA: code = KEY_9;
            4'hB: code = KEY_C;
            4'hC: code = KEY_STAR;
            4'hD: code = KEY_0;
            4'hE: code = KEY_HASH;
            4'hF: code = KEY_D;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// keypad_scanner: column scan, row synchronizer, debounce and key decode.
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   row_in     keypad rows, active-low, asynchronous
//   col_out    column drive, active-low, one-hot-low
//   key_valid  one-cycle pulse per accepted press
//   key_code   code of the accepted key, valid with key_valid
//
// state       | meaning
// ------------|---------------------------------------------------------
// ST_SCAN     | rotating columns, looking for any low row at each tick
// ST_DEBOUNCE | column held, confirming the latched row stays low
// ST_RELEASE  | column held, waiting for all rows high long enough
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 262144,
    parameter int DEBOUNCE_N = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_N + 1);

    logic [3:0]    row_meta, row_sync;
    logic [TW-1:0] tick_cnt;
    logic          tick;

    scan_state_t   state, state_nx;
    logic [1:0]    col_idx, col_nx;
    logic [1:0]    lat_row, row_nx;
    logic [DW-1:0] deb_cnt, cnt_nx, deb_inc;
    logic          kv_nx;
    logic [3:0]    code_nx;

    logic          any_low;
    logic [1:0]    low_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    // The tick marks the last cycle of a column period; rows are sampled then.
    assign tick = (tick_cnt == TW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TW'(1);
    end

    // Lowest-index low row wins when several are pressed.
    always_comb begin
        any_low = (row_sync != 4'hF);
        low_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_sync[r])
                low_row = 2'(r);
        end
    end

    assign deb_inc = deb_cnt + DW'(1);

    always_comb begin
        state_nx = state;
        col_nx   = col_idx;
        row_nx   = lat_row;
        cnt_nx   = deb_cnt;
        kv_nx    = 1'b0;
        code_nx  = key_code;
        if (tick) begin
            case (state)
                ST_SCAN: begin
                    if (any_low) begin
                        row_nx = low_row;
                        if (DEBOUNCE_N <= 1) begin
                            kv_nx    = 1'b1;
                            code_nx  = key_lookup(low_row, col_idx);
                            state_nx = ST_RELEASE;
                            cnt_nx   = '0;
                        end else begin
                            state_nx = ST_DEBOUNCE;
                            cnt_nx   = DW'(1);
                        end
                    end else begin
                        col_nx = col_idx + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!row_sync[lat_row]) begin
                        if (deb_inc == DW'(DEBOUNCE_N)) begin
                            kv_nx    = 1'b1;
                            code_nx  = key_lookup(lat_row, col_idx);
                            state_nx = ST_RELEASE;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = deb_inc;
                        end
                    end else begin
                        state_nx = ST_SCAN;
                        cnt_nx   = '0;
                        col_nx   = col_idx + 2'd1;
                    end
                end
                ST_RELEASE: begin
                    if (row_sync == 4'hF) begin
                        if (deb_inc == DW'(DEBOUNCE_N)) begin
                            state_nx = ST_SCAN;
                            cnt_nx   = '0;
                            col_nx   = col_idx + 2'd1;
                        end else begin
                            cnt_nx = deb_inc;
                        end
                    end else begin
                        cnt_nx = '0;
                    end
                end
                default: begin
                    state_nx = ST_SCAN;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SCAN;
            col_idx   <= 2'd0;
            lat_row   <= 2'd0;
            deb_cnt   <= '0;
            key_valid <= 1'b0;
            key_code  <= KEY_0;
        end else begin
            state     <= state_nx;
            col_idx   <= col_nx;
            lat_row   <= row_nx;
            deb_cnt   <= cnt_nx;
            key_valid <= kv_nx;
            key_code  <= code_nx;
        end
    end

    assign col_out = ~(4'b0001 << col_idx);

endmodule

// File: rtl/keypad_number_entry.sv
// keypad_number_entry: keypad operand entry, up to three digits plus sign.
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   row_in       keypad rows, active-low, asynchronous
//   col_out      keypad column drive, active-low
//   entry        live signed value, 13-bit two's complement
//   negative     current sign flag
//   digit_count  digits entered so far, 0..3
//   num          last confirmed value, 13-bit two's complement
//   num_valid    one-cycle pulse when num updates
module keypad_number_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 262144,
    parameter int DEBOUNCE_N = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [12:0] entry,
    output logic        negative,
    output logic [1:0]  digit_count,
    output logic [12:0] num,
    output logic        num_valid
);

    logic       key_valid;
    logic [3:0] key_code;
    logic [9:0] mag;
    logic [9:0] mag_app;
    logic [13:0] mag_wide;

    keypad_scanner #(
        .SCAN_DIV   (SCAN_DIV),
        .DEBOUNCE_N (DEBOUNCE_N)
    ) u_scanner (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    // Appending happens only below three digits, so mag <= 99 here and the
    // result (<= 999) always fits in ten bits.
    always_comb begin
        mag_wide = ({4'd0, mag} * 14'd10) + {10'd0, key_code};
        mag_app  = mag_wide[9:0];
    end

    // A negative zero reads as 0 while the sign flag stays set.
    assign entry = negative ? (13'd0 - {3'd0, mag}) : {3'd0, mag};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag         <= 10'd0;
            digit_count <= 2'd0;
            negative    <= 1'b0;
            num         <= 13'd0;
            num_valid   <= 1'b0;
        end else begin
            num_valid <= 1'b0;
            if (key_valid) begin
                if (key_code <= KEY_9) begin
                    if (digit_count < 2'd3) begin
                        mag         <= mag_app;
                        digit_count <= digit_count + 2'd1;
                    end
                end else if (key_code == KEY_STAR) begin
                    negative <= ~negative;
                end else if (key_code == KEY_C) begin
                    mag         <= 10'd0;
                    digit_count <= 2'd0;
                    negative    <= 1'b0;
                end else if (key_code == KEY_HASH) begin
                    num         <= entry;
                    num_valid   <= 1'b1;
                    mag         <= 10'd0;
                    digit_count <= 2'd0;
                    negative    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_number_entry.sv
module tb_keypad_number_entry;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [12:0] entry;
    logic        negative;
    logic [1:0]  digit_count;
    logic [12:0] num;
    logic        num_valid;

    logic [15:0] pressed;   // bit r*4+c: key at (row r, col c) held down
    int          n_tests;
    int          n_fail;
    int          nv_cnt;

    // behavioural reference
    int          m_mag;
    int          m_dc;
    bit          m_neg;
    int          m_num;
    int          m_nv;

    string       layout;

    keypad_number_entry #(
        .SCAN_DIV   (4),
        .DEBOUNCE_N (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_in      (row_in),
        .col_out     (col_out),
        .entry       (entry),
        .negative    (negative),
        .digit_count (digit_count),
        .num         (num),
        .num_valid   (num_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: a pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_out[c])
                    row_in[r] = 1'b0;
    end

    always @(negedge clk)
        if (num_valid === 1'b1)
            nv_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int key_index(input byte ch);
        for (int i = 0; i < 16; i++)
            if (layout[i] == ch)
                return i;
        return 0;
    endfunction

    function automatic int model_entry();
        int e;
        e = m_neg ? -m_mag : m_mag;
        return e & 'h1FFF;
    endfunction

    function automatic void model_clear();
        m_mag = 0;
        m_dc  = 0;
        m_neg = 0;
    endfunction

    function automatic void model_apply(input byte ch);
        if (ch >= "0" && ch <= "9") begin
            if (m_dc < 3) begin
                m_mag = m_mag * 10 + int'(ch - "0");
                m_dc++;
            end
        end else if (ch == "*") begin
            m_neg = !m_neg;
        end else if (ch == "C") begin
            model_clear();
        end else if (ch == "#") begin
            m_num = model_entry();
            m_nv++;
            model_clear();
        end
    endfunction

    task automatic tap(input byte ch, input int hold);
        int idx;
        idx = key_index(ch);
        pressed[idx] = 1'b1;
        repeat (hold) @(posedge clk);
        pressed[idx] = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".entry"},    32'(entry),       32'(model_entry()));
        check({tag, ".dcount"},   32'(digit_count), 32'(m_dc));
        check({tag, ".negative"}, 32'(negative),    32'(m_neg));
        check({tag, ".num"},      32'(num),         32'(m_num));
        check({tag, ".nv_count"}, 32'(nv_cnt),      32'(m_nv));
    endtask

    task automatic wait_col(input logic [3:0] want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (col_out == want) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        byte         key;
        logic [12:0] e_entry;
        int          e_dc;
        bit          e_neg;
        logic [12:0] e_num;
        int          e_nv;
    } vec_t;

    vec_t vecs[13];

    initial begin
        bit ok;
        int idx;
        byte ch;

        layout  = "123A456B789C*0#D";
        n_tests = 0;
        n_fail  = 0;
        nv_cnt  = 0;
        pressed = 16'h0;
        m_num   = 0;
        m_nv    = 0;
        model_clear();

        vecs[0]  = '{"1", 13'd1,      1, 1'b0, 13'd0,      0};
        vecs[1]  = '{"2", 13'd12,     2, 1'b0, 13'd0,      0};
        vecs[2]  = '{"3", 13'd123,    3, 1'b0, 13'd0,      0};
        vecs[3]  = '{"#", 13'd0,      0, 1'b0, 13'd123,    1};
        vecs[4]  = '{"*", 13'd0,      0, 1'b1, 13'd123,    1};
        vecs[5]  = '{"4", 13'h1FFC,   1, 1'b1, 13'd123,    1};
        vecs[6]  = '{"5", 13'h1FD3,   2, 1'b1, 13'd123,    1};
        vecs[7]  = '{"#", 13'd0,      0, 1'b0, 13'h1FD3,   2};
        vecs[8]  = '{"9", 13'd9,      1, 1'b0, 13'h1FD3,   2};
        vecs[9]  = '{"9", 13'd99,     2, 1'b0, 13'h1FD3,   2};
        vecs[10] = '{"9", 13'd999,    3, 1'b0, 13'h1FD3,   2};
        vecs[11] = '{"7", 13'd999,    3, 1'b0, 13'h1FD3,   2};
        vecs[12] = '{"C", 13'd0,      0, 1'b0, 13'h1FD3,   2};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.col_out",  32'(col_out),     32'hE);
        check("reset.entry",    32'(entry),       32'd0);
        check("reset.num",      32'(num),         32'd0);
        check("reset.nvalid",   32'(num_valid),   32'd0);
        check("reset.negative", 32'(negative),    32'd0);
        check("reset.dcount",   32'(digit_count), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed table: digits/enter, negative entry, digit limit, clear
        for (int i = 0; i < 13; i++) begin
            tap(vecs[i].key, 40);
            model_apply(vecs[i].key);
            check($sformatf("vec%0d.entry", i),    32'(entry),       32'(vecs[i].e_entry));
            check($sformatf("vec%0d.dcount", i),   32'(digit_count), 32'(vecs[i].e_dc));
            check($sformatf("vec%0d.negative", i), 32'(negative),    32'(vecs[i].e_neg));
            check($sformatf("vec%0d.num", i),      32'(num),         32'(vecs[i].e_num));
            check($sformatf("vec%0d.nv_count", i), 32'(nv_cnt),      32'(vecs[i].e_nv));
        end

        // Bounce on key 4 (row1,col0), then a steady hold: one event only
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            pressed[4] = ~pressed[4];
        end
        pressed[4] = 1'b1;
        repeat (40) @(posedge clk);
        pressed[4] = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        model_apply("4");
        check_model("bounce");

        // Single-cycle glitch on key 5 while its column is driven: no event
        wait_col(4'b1101, ok);
        check("glitch.wait_col1", 32'(ok), 32'd1);
        @(posedge clk);
        pressed[5] = 1'b1;
        @(posedge clk);
        pressed[5] = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check_model("glitch");

        // Long hold: no auto-repeat
        tap("5", 200);
        model_apply("5");
        check_model("hold5");

        // Rows 0 and 2 on column 1 together: lower row (key 2) wins
        pressed[1] = 1'b1;
        pressed[9] = 1'b1;
        repeat (40) @(posedge clk);
        pressed[1] = 1'b0;
        pressed[9] = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        model_apply("2");
        check_model("multikey");

        tap("*", 40);
        model_apply("*");
        check_model("pre_reset");

        // Reset while '*' is being debounced; key kept held through release
        wait_col(4'b0111, ok);
        check("rst.wait_col3", 32'(ok), 32'd1);
        pressed[12] = 1'b1;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst.col_out",  32'(col_out),     32'hE);
        check("rst.entry",    32'(entry),       32'd0);
        check("rst.num",      32'(num),         32'd0);
        check("rst.nvalid",   32'(num_valid),   32'd0);
        check("rst.negative", 32'(negative),    32'd0);
        check("rst.dcount",   32'(digit_count), 32'd0);
        model_clear();
        m_num = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        pressed[12] = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        model_apply("*");
        check_model("post_reset_star");
        tap("#", 40);
        model_apply("#");
        check_model("enter_zero");

        // Randomized key sequence against the reference model
        for (int i = 0; i < 80; i++) begin
            idx = int'($urandom_range(0, 15));
            ch  = layout[idx];
            tap(ch, int'($urandom_range(30, 60)));
            model_apply(ch);
            check_model($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
